// File: rtl/dvp_frame_gate.sv
// Frame-aligned gate from DVP capture to the DDR3 write FIFO: skips settling frames,
// forces exactly IMAGE_WIDTH*IMAGE_HEIGHT words per frame. Option: FRAME_GATE_TEST_PATTERN_EN.
module dvp_frame_gate #(
    parameter int                IMAGE_WIDTH  = 1280,
    parameter int                IMAGE_HEIGHT = 720,
    parameter int                DATA_W       = 32,
    parameter int                SKIP_FRAMES  = 2,
    parameter logic [DATA_W-1:0] PAD_VALUE    = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              in_vsync,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
`ifdef FRAME_GATE_TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    output logic              out_wren,
    output logic [DATA_W-1:0] out_data,
    output logic              out_load,
    output logic [15:0]       frame_cnt,
    output logic              err_short,
    output logic              err_long,
    output logic              busy
);
    localparam longint     TOTAL_L = longint'(IMAGE_WIDTH) * longint'(IMAGE_HEIGHT);
    localparam logic [23:0] TOTAL   = 24'(TOTAL_L);
    localparam logic [23:0] TOTAL_M1 = TOTAL - 24'd1;
    localparam logic [3:0]  SKIP_N  = 4'(SKIP_FRAMES);

    generate
        if (TOTAL_L >= 64'd16777216) begin : g_total_chk
            $error("dvp_frame_gate: IMAGE_WIDTH*IMAGE_HEIGHT must fit in 24 bits");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SKIP, ACTIVE, PAD} state_t;

    state_t            r_state, w_state_n;
    logic              r_en_meta, r_en_s, r_vs_d;
    logic [3:0]        r_skip_cnt, w_skip_n;
    logic [23:0]       r_pix_cnt, w_pix_n;
    logic              r_pend, w_pend_n, r_load_pend, w_load_pend_n;
    logic [DATA_W-1:0] r_pend_data, w_pend_data_n;
    logic              r_wren, w_wren_n, r_load, w_load_n, r_busy, w_busy_n;
    logic [DATA_W-1:0] r_data, w_data_n, w_data_o;
    logic [15:0]       r_frame_cnt, w_frame_n;
    logic              r_err_short, w_err_s_n, r_err_long, w_err_l_n;
    logic              w_sof, w_full, w_restart;

    assign w_sof  = r_vs_d & ~in_vsync;
    assign w_full = (r_pix_cnt == TOTAL);

    always_comb begin
        w_state_n     = r_state;
        w_skip_n      = r_skip_cnt;
        w_pix_n       = r_pix_cnt;
        w_pend_n      = r_pend;
        w_pend_data_n = r_pend_data;
        w_load_pend_n = r_load_pend;
        w_wren_n      = 1'b0;
        w_data_n      = r_data;
        w_load_n      = 1'b0;
        w_frame_n     = r_frame_cnt;
        w_err_s_n     = r_err_short;
        w_err_l_n     = r_err_long;
        w_restart     = r_load_pend | (w_sof & w_full);
        if (!r_en_s) begin
            w_state_n     = IDLE;
            w_pix_n       = '0;
            w_pend_n      = 1'b0;
            w_load_pend_n = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_n = SKIP;
                    w_skip_n  = '0;
                    w_err_s_n = 1'b0;
                    w_err_l_n = 1'b0;
                end
                SKIP: if (w_sof) begin
                    if (r_skip_cnt == SKIP_N) begin
                        // A pixel arriving with the start SOF is held one cycle so it lands after the load
                        w_state_n     = ACTIVE;
                        w_load_n      = 1'b1;
                        w_pend_n      = in_valid;
                        w_pend_data_n = in_data;
                        w_pix_n       = in_valid ? 24'd1 : 24'd0;
                    end else begin
                        w_skip_n = r_skip_cnt + 4'd1;
                    end
                end
                ACTIVE: begin
                    if (w_restart && !r_pend) begin
                        w_load_n      = 1'b1;
                        w_frame_n     = r_frame_cnt + 16'd1;
                        w_load_pend_n = 1'b0;
                        w_pend_n      = in_valid;
                        w_pend_data_n = in_data;
                        w_pix_n       = in_valid ? 24'd1 : 24'd0;
                    end else begin
                        // A pending write occupies this cycle, so the load slips by one
                        if (w_restart) w_load_pend_n = 1'b1;
                        if (r_pend) begin
                            w_wren_n = 1'b1;
                            w_data_n = r_pend_data;
                            w_pend_n = 1'b0;
                        end
                        if (in_valid) begin
                            if (!w_full && !w_restart) begin
                                w_pix_n = r_pix_cnt + 24'd1;
                                if (r_pend) begin
                                    w_pend_n      = 1'b1;
                                    w_pend_data_n = in_data;
                                end else begin
                                    w_wren_n = 1'b1;
                                    w_data_n = in_data;
                                end
                            end else begin
                                w_err_l_n = 1'b1;
                            end
                        end
                        if (w_sof && !w_full) begin
                            if (in_valid && r_pix_cnt == TOTAL_M1) begin
                                w_load_pend_n = 1'b1;
                            end else begin
                                w_state_n = PAD;
                                w_err_s_n = 1'b1;
                            end
                        end
                    end
                end
                PAD: begin
                    w_wren_n = 1'b1;
                    if (in_valid) w_err_l_n = 1'b1;
                    if (r_pend) begin
                        w_data_n = r_pend_data;
                        w_pend_n = 1'b0;
                    end else begin
                        w_data_n = PAD_VALUE;
                        if (r_pix_cnt == TOTAL_M1) begin
                            w_load_n  = 1'b1;
                            w_frame_n = r_frame_cnt + 16'd1;
                            w_pix_n   = '0;
                            w_state_n = ACTIVE;
                        end else begin
                            w_pix_n = r_pix_cnt + 24'd1;
                        end
                    end
                end
                default: w_state_n = IDLE;
            endcase
        end
        w_busy_n = (w_state_n == ACTIVE) || (w_state_n == PAD);
    end

`ifdef FRAME_GATE_TEST_PATTERN_EN
    localparam int BAR_W = (IMAGE_WIDTH >= 8) ? IMAGE_WIDTH / 8 : 1;
    localparam int COL_W = $clog2(IMAGE_WIDTH + 1);
    logic [COL_W-1:0]  r_col;
    logic [2:0]        w_bar;
    logic [DATA_W-1:0] w_bar_data;

    // Bar index bits map straight to channel enables: R=~b[1], G=~b[2], B=~b[0]
    always_comb begin
        w_bar = 3'd7;
        if (int'(r_col) / BAR_W < 8) w_bar = 3'(int'(r_col) / BAR_W);
        w_bar_data = DATA_W'({8'h00, {8{~w_bar[1]}}, {8{~w_bar[2]}}, {8{~w_bar[0]}}});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          r_col <= '0;
        else if (w_load_n || r_state == IDLE)  r_col <= '0;
        else if (w_wren_n)                     r_col <= (int'(r_col) == IMAGE_WIDTH - 1) ? '0 : r_col + COL_W'(1);
    end

    assign w_data_o = (test_mode && w_wren_n) ? w_bar_data : w_data_n;
`else
    assign w_data_o = w_data_n;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en_meta   <= 1'b0;
            r_en_s      <= 1'b0;
            r_vs_d      <= 1'b0;
            r_state     <= IDLE;
            r_skip_cnt  <= '0;
            r_pix_cnt   <= '0;
            r_pend      <= 1'b0;
            r_pend_data <= '0;
            r_load_pend <= 1'b0;
            r_wren      <= 1'b0;
            r_data      <= '0;
            r_load      <= 1'b0;
            r_frame_cnt <= '0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_en_meta   <= enable;
            r_en_s      <= r_en_meta;
            r_vs_d      <= in_vsync;
            r_state     <= w_state_n;
            r_skip_cnt  <= w_skip_n;
            r_pix_cnt   <= w_pix_n;
            r_pend      <= w_pend_n;
            r_pend_data <= w_pend_data_n;
            r_load_pend <= w_load_pend_n;
            r_wren      <= w_wren_n;
            r_data      <= w_data_o;
            r_load      <= w_load_n;
            r_frame_cnt <= w_frame_n;
            r_err_short <= w_err_s_n;
            r_err_long  <= w_err_l_n;
            r_busy      <= w_busy_n;
        end
    end

    assign out_wren  = r_wren;
    assign out_data  = r_data;
    assign out_load  = r_load;
    assign frame_cnt = r_frame_cnt;
    assign err_short = r_err_short;
    assign err_long  = r_err_long;
    assign busy      = r_busy;
endmodule

// File: tb/tb_dvp_frame_gate.sv
// Directed bench for dvp_frame_gate with an 8x4 image (32 words per frame) and 2 skipped frames.
module tb_dvp_frame_gate;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          in_vsync = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_wren, out_load, err_short, err_long, busy;
    logic [DW-1:0] out_data;
    logic [15:0]   frame_cnt;

    int            n_chk = 0;
    int            n_bad = 0;
    logic [DW-1:0] wr_log[$];
    int            load_cnt = 0;
    int            load_at_wr = -1;
    int            coinc_bad = 0;

    dvp_frame_gate #(
        .IMAGE_WIDTH (8),
        .IMAGE_HEIGHT(4),
        .DATA_W      (DW),
        .SKIP_FRAMES (2),
        .PAD_VALUE   ('0)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .in_vsync (in_vsync),
        .in_valid (in_valid),
        .in_data  (in_data),
`ifdef FRAME_GATE_TEST_PATTERN_EN
        .test_mode(1'b0),
`endif
        .out_wren (out_wren),
        .out_data (out_data),
        .out_load (out_load),
        .frame_cnt(frame_cnt),
        .err_short(err_short),
        .err_long (err_long),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Outputs move on posedge; log them on the following negedge
    always @(negedge clk) begin
        if (out_wren) wr_log.push_back(out_data);
        if (out_load) begin
            load_cnt   = load_cnt + 1;
            load_at_wr = wr_log.size();
            if (out_wren && out_data != '0) coinc_bad = coinc_bad + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // vsync pulse, SOF, 4 idle cycles, n pixels base+i, 3 idle cycles
    task automatic frame(input int n, input logic [31:0] base);
        in_vsync = 1'b1; cyc(2);
        in_vsync = 1'b0; cyc(5);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1; in_data = base + 32'(i); cyc(1);
        end
        in_valid = 1'b0; cyc(3);
    endtask

    initial begin
        int nb;
        cyc(3);
        chk("rst_wren", {31'd0, out_wren}, 32'd0);
        chk("rst_load", {31'd0, out_load}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame", {16'd0, frame_cnt}, 32'd0);
        chk("rst_err", {30'd0, err_short, err_long}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        reset_n = 1'b1; enable = 1'b1; cyc(4);

        // 1: two skipped frames, capture from the third SOF
        frame(32, 32'h100);
        frame(32, 32'h200);
        chk("skip_nowr", wr_log.size(), 32'd0);
        chk("skip_noload", load_cnt, 32'd0);
        frame(32, 32'h300);
        chk("f3_count", wr_log.size(), 32'd32);
        chk("f3_load", load_cnt, 32'd1);
        chk("f3_load_pos", load_at_wr, 32'd0);
        nb = 0;
        for (int i = 0; i < 32; i++) if (wr_log[i] !== 32'h300 + 32'(i)) nb++;
        chk("f3_data", nb, 32'd0);
        chk("f3_busy", {31'd0, busy}, 32'd1);

        // 2: steady frames
        frame(32, 32'h400);
        frame(32, 32'h500);
        chk("st_frame", {16'd0, frame_cnt}, 32'd2);
        chk("st_load", load_cnt, 32'd3);
        chk("st_load_pos", load_at_wr, 32'd64);
        chk("st_count", wr_log.size(), 32'd96);
        chk("st_last", wr_log[95], 32'h51F);
        chk("st_err", {30'd0, err_short, err_long}, 32'd0);

        // 3: short frame of 29 gets 3 pad words, load on the last
        frame(29, 32'h600);
        chk("sh_pre_count", wr_log.size(), 32'd125);
        frame(32, 32'h700);
        chk("sh_pad0", wr_log[125], 32'd0);
        chk("sh_pad1", wr_log[126], 32'd0);
        chk("sh_pad2", wr_log[127], 32'd0);
        chk("sh_load_pos", load_at_wr, 32'd128);
        chk("sh_next_first", wr_log[128], 32'h700);
        chk("sh_count", wr_log.size(), 32'd160);
        chk("sh_frame", {16'd0, frame_cnt}, 32'd4);
        chk("sh_err_short", {31'd0, err_short}, 32'd1);
        chk("sh_err_long", {31'd0, err_long}, 32'd0);

        // 4: long frame of 35 truncated to 32; the preceding frame closes with no padding
        frame(35, 32'h800);
        chk("lg_prev_load_pos", load_at_wr, 32'd160);
        chk("lg_frame_a", {16'd0, frame_cnt}, 32'd5);
        chk("lg_count", wr_log.size(), 32'd192);
        chk("lg_last", wr_log[191], 32'h81F);
        chk("lg_err_long", {31'd0, err_long}, 32'd1);
        frame(32, 32'h900);
        chk("lg_next_load_pos", load_at_wr, 32'd192);
        chk("lg_frame_b", {16'd0, frame_cnt}, 32'd6);
        chk("lg_next_count", wr_log.size(), 32'd224);

        // 5: enable drops after 10 pixels; two in-flight pixels still land
        in_vsync = 1'b1; cyc(2);
        in_vsync = 1'b0; cyc(5);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 32'hA00 + 32'(i); cyc(1);
        end
        enable = 1'b0;
        for (int i = 10; i < 16; i++) begin
            in_valid = 1'b1; in_data = 32'hA00 + 32'(i); cyc(1);
        end
        in_valid = 1'b0; cyc(3);
        chk("dis_count", wr_log.size(), 32'd236);
        chk("dis_last", wr_log[235], 32'hA0B);
        chk("dis_load", load_cnt, 32'd8);
        chk("dis_wren", {31'd0, out_wren}, 32'd0);
        chk("dis_busy", {31'd0, busy}, 32'd0);
        chk("dis_frame", {16'd0, frame_cnt}, 32'd7);
        chk("dis_err_held", {30'd0, err_short, err_long}, 32'd3);
        enable = 1'b1; cyc(4);
        frame(32, 32'hB00);
        frame(32, 32'hC00);
        chk("re_skip_count", wr_log.size(), 32'd236);
        chk("re_err_clr", {30'd0, err_short, err_long}, 32'd0);
        chk("re_skip_busy", {31'd0, busy}, 32'd0);
        frame(32, 32'hD00);
        chk("re_count", wr_log.size(), 32'd268);
        chk("re_first", wr_log[236], 32'hD00);
        chk("re_load", load_cnt, 32'd9);
        chk("re_load_pos", load_at_wr, 32'd236);
        chk("re_frame", {16'd0, frame_cnt}, 32'd7);

        // 6: asynchronous reset in the middle of a long pad
        frame(5, 32'hE00);
        in_vsync = 1'b1; cyc(2);
        in_vsync = 1'b0; cyc(3);
        chk("pad_wren", {31'd0, out_wren}, 32'd1);
        chk("pad_busy", {31'd0, busy}, 32'd1);
        chk("pad_err_short", {31'd0, err_short}, 32'd1);
        chk("pad_frame", {16'd0, frame_cnt}, 32'd8);
        chk("coinc", coinc_bad, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("ar_wren", {31'd0, out_wren}, 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_frame", {16'd0, frame_cnt}, 32'd0);
        chk("ar_err", {30'd0, err_short, err_long}, 32'd0);
        chk("ar_data", out_data, 32'd0);
        cyc(2);
        reset_n = 1'b1; cyc(3);
        chk("post_busy", {31'd0, busy}, 32'd0);
        chk("post_wren", {31'd0, out_wren}, 32'd0);
        chk("post_frame", {16'd0, frame_cnt}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
